iir_coef_ctrl: RTL and testbench
================================

# iir_coef_ctrl

Coefficient configuration controller for the IIR notch filter datapath. Accepts coefficient writes into a shadow bank over a valid/ready port and commits all five coefficients (A1, A2, B0, B1, B2) atomically on a sample boundary. After each commit it holds the filter's state registers in reset for a programmable flush interval, so stale x[n]/y[n] history never mixes with new coefficients. Sits between the host/config bus and the filter core's coefficient inputs and `rst_n`.

## Interface
Parameters:
- `COEF_W`, 16, coefficient width, signed Q2.14 (1.0 = 0x4000)
- `FLUSH_CYCLES`, 8, cycles `filt_rst_n` is held low after reset release and after each commit; legal range 1..255

Ports:
- `clk`  in  1  system clock
- `rst_n`  in  1  reset; asynchronous, active-low
- `wr_valid`  in  1  coefficient write request
- `wr_ready`  out  1  write accepted when `wr_valid && wr_ready` at a rising edge
- `wr_addr`  in  3  0=A1, 1=A2, 2=B0, 3=B1, 4=B2; 5..7 illegal
- `wr_data`  in  COEF_W  signed coefficient value
- `commit`  in  1  single-cycle request to activate the shadow bank
- `sample_strobe`  in  1  high for one cycle at each filter input sample boundary
- `A1`, `A2`, `B0`, `B1`, `B2`  out  COEF_W each  active coefficients to the filter
- `filt_rst_n`  out  1  active-low reset to the filter core
- `busy`  out  1  high in every state except RUN
- `err`  out  1  one-cycle pulse on an illegal-address write

## Operation
- States: INIT_FLUSH, RUN, PENDING, FLUSH. Reset enters INIT_FLUSH with counter = FLUSH_CYCLES.
- Reset values:
  - Active and shadow banks = passthrough (B0=0x4000, all others 0).
  - `filt_rst_n`=0, `wr_ready`=0, `busy`=1, `err`=0.
- INIT_FLUSH / FLUSH:
  - `filt_rst_n`=0, `wr_ready`=0; counter decrements each cycle.
  - When the counter reaches 1, the FSM goes to RUN on the next edge.
- RUN:
  - `wr_ready`=1; an accepted write updates the shadow entry at `wr_addr`.
  - `commit` moves the FSM to PENDING.
- PENDING:
  - `wr_ready`=0.
  - On `sample_strobe`: active bank <= shadow bank, counter <= FLUSH_CYCLES, FSM goes to FLUSH.
- Shadow bank persists across commits. Unwritten entries keep their previously written (or reset) values, so every commit is legal.
- Illegal address (5..7): the handshake completes, data is discarded, `err` pulses one cycle.
- Ignored inputs: `commit` outside RUN; `sample_strobe` outside PENDING.
- Same-cycle write and `commit` in RUN: the write lands in the shadow bank and is included in the commit.
- `rst_n` asserted mid-operation (any state): everything returns to reset values immediately, including the shadow bank. Any pending commit is lost.

## Timing
- All outputs are registered.
- Write latency: an accepted write is visible in the shadow bank the next cycle. It never reaches the outputs until a commit.
- Commit latency:
  - Active coefficients change on the edge after the first `sample_strobe` seen in PENDING.
  - `filt_rst_n` falls on that same edge.
- Flush length: `filt_rst_n` is low for exactly FLUSH_CYCLES cycles, then rises together with the RUN entry (`wr_ready`=1, `busy`=0).
- After `rst_n` deasserts, `filt_rst_n` rises after FLUSH_CYCLES edges.
- Coefficient outputs are stable whenever `filt_rst_n`=1.

## Configuration
- `IIR_COEF_READBACK_EN`
  - Defined: adds `rd_addr` (in, 3) and `rd_data` (out, COEF_W). `rd_data` is registered, one-cycle latency, and returns the active coefficient for addresses 0..4 and 0 for 5..7. It resets to 0.
  - Undefined: these ports and their logic do not exist, and behaviour is otherwise identical.

## Structure
- Shared package `iir_pkg` holds:
  - address constants `ADDR_A1`..`ADDR_B2`
  - passthrough reset values (`COEF_ONE` = 0x4000)
  - the state enum `iir_ctrl_state_t`
- One sub-module, `flush_timer`: loadable down-counter with a `done` output, used for both INIT_FLUSH and FLUSH.

## Test plan
- Reset release with FLUSH_CYCLES=8 -> `filt_rst_n` low for 8 edges then high; outputs B0=0x4000, others 0; `busy` falls with `filt_rst_n` rise.
- Write A1=0xC000, B0=0x3000, then `commit`; `sample_strobe` 5 cycles later -> outputs unchanged until the strobe edge; then A1=0xC000, B0=0x3000, A2/B1/B2=0; `filt_rst_n` low 8 cycles.
- Write to addr 6 with data 0x1234 -> `wr_ready` handshake completes, `err` high exactly one cycle, no shadow change (verify via readback if `IIR_COEF_READBACK_EN`).
- Same-cycle write B2=0x0800 and `commit` -> after strobe, B2=0x0800 active.
- `commit` during FLUSH and `sample_strobe` in RUN -> no state change; `wr_valid` in PENDING/FLUSH sees `wr_ready`=0 and the write is not taken.
- `rst_n` pulsed low while in PENDING -> immediate return to passthrough coefficients, `filt_rst_n`=0, shadow cleared; a later commit with no writes yields passthrough.

Source files
------------

// File: rtl/iir_pkg.sv
// Shared definitions for the IIR notch filter coefficient controller:
// coefficient addresses, passthrough reset values and controller states.
package iir_pkg;

  localparam int unsigned NUM_COEF = 5;
  localparam int unsigned ADDR_W   = 3;
  localparam int unsigned CNT_W    = 8;

  localparam logic [ADDR_W-1:0] ADDR_A1 = 3'd0;
  localparam logic [ADDR_W-1:0] ADDR_A2 = 3'd1;
  localparam logic [ADDR_W-1:0] ADDR_B0 = 3'd2;
  localparam logic [ADDR_W-1:0] ADDR_B1 = 3'd3;
  localparam logic [ADDR_W-1:0] ADDR_B2 = 3'd4;

  // Q2.14 unity gain; B0 = 1.0 with all other taps zero is a passthrough filter
  localparam logic [15:0] COEF_ONE = 16'h4000;

  typedef enum logic [1:0] {
    ST_INIT_FLUSH = 2'd0,
    ST_RUN        = 2'd1,
    ST_PENDING    = 2'd2,
    ST_FLUSH      = 2'd3
  } iir_ctrl_state_t;

  function automatic logic addr_legal(input logic [ADDR_W-1:0] addr);
    return addr <= ADDR_B2;
  endfunction

endpackage

// File: rtl/iir_coef_ctrl_flush_timer.sv
// Loadable down-counter timing the filter flush; done is high while the count is 1.
module flush_timer
  import iir_pkg::*;
#(
  parameter int unsigned RST_VAL = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Count saturates at 1 so done stays asserted until the next load
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (en && (count_q > CNT_W'(1))) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= CNT_W'(RST_VAL);
      done    <= (CNT_W'(RST_VAL) == CNT_W'(1));
    end else begin
      count_q <= count_d;
      done    <= (count_d == CNT_W'(1));
    end
  end

endmodule

// File: rtl/iir_coef_ctrl.sv
// Shadow/active coefficient bank controller with sample-aligned commit and filter flush.
// Optional readback port enabled by defining IIR_COEF_READBACK_EN.
module iir_coef_ctrl
  import iir_pkg::*;
#(
  parameter int unsigned COEF_W       = 16,
  parameter int unsigned FLUSH_CYCLES = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [COEF_W-1:0] wr_data,
  input  logic              commit,
  input  logic              sample_strobe,
`ifdef IIR_COEF_READBACK_EN
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [COEF_W-1:0] rd_data,
`endif
  output logic [COEF_W-1:0] A1,
  output logic [COEF_W-1:0] A2,
  output logic [COEF_W-1:0] B0,
  output logic [COEF_W-1:0] B1,
  output logic [COEF_W-1:0] B2,
  output logic              filt_rst_n,
  output logic              busy,
  output logic              err
);

  iir_ctrl_state_t state_q;
  iir_ctrl_state_t state_d;

  logic timer_load;
  logic timer_en;
  logic timer_done;
  logic wr_accept;
  logic bank_swap;

  logic [COEF_W-1:0] shadow_q [NUM_COEF];
  logic [COEF_W-1:0] active_q [NUM_COEF];

  assign wr_accept = wr_valid && wr_ready;
  assign bank_swap = (state_q == ST_PENDING) && sample_strobe;

  flush_timer #(
    .RST_VAL (FLUSH_CYCLES)
  ) u_flush_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (timer_load),
    .en       (timer_en),
    .load_val (CNT_W'(FLUSH_CYCLES)),
    .done     (timer_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_INIT_FLUSH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    timer_load = 1'b0;
    timer_en   = 1'b0;
    case (state_q)
      ST_INIT_FLUSH, ST_FLUSH: begin
        timer_en = 1'b1;
        if (timer_done) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (commit) begin
          state_d = ST_PENDING;
        end
      end
      ST_PENDING: begin
        if (sample_strobe) begin
          timer_load = 1'b1;
          state_d    = ST_FLUSH;
        end
      end
      default: state_d = ST_INIT_FLUSH;
    endcase
  end

  // Status outputs are registered from the next state so they align with it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_rst_n <= 1'b0;
      wr_ready   <= 1'b0;
      busy       <= 1'b1;
      err        <= 1'b0;
    end else begin
      filt_rst_n <= (state_d == ST_RUN) || (state_d == ST_PENDING);
      wr_ready   <= (state_d == ST_RUN);
      busy       <= (state_d != ST_RUN);
      err        <= wr_accept && !addr_legal(wr_addr);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_COEF; i++) begin
        shadow_q[i] <= (i == 32'(ADDR_B0)) ? COEF_W'(COEF_ONE) : '0;
        active_q[i] <= (i == 32'(ADDR_B0)) ? COEF_W'(COEF_ONE) : '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_COEF; i++) begin
        if (wr_accept && (wr_addr == ADDR_W'(i))) begin
          shadow_q[i] <= wr_data;
        end
        if (bank_swap) begin
          active_q[i] <= shadow_q[i];
        end
      end
    end
  end

  assign A1 = active_q[ADDR_A1];
  assign A2 = active_q[ADDR_A2];
  assign B0 = active_q[ADDR_B0];
  assign B1 = active_q[ADDR_B1];
  assign B2 = active_q[ADDR_B2];

`ifdef IIR_COEF_READBACK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else begin
      rd_data <= '0;
      for (int unsigned i = 0; i < NUM_COEF; i++) begin
        if (rd_addr == ADDR_W'(i)) begin
          rd_data <= active_q[i];
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_iir_coef_ctrl.sv
// Self-checking bench for iir_coef_ctrl: directed sequences, a vector table and a
// randomized run against a behavioural model.
module tb_iir_coef_ctrl;

  localparam int unsigned W  = 16;
  localparam int unsigned FC = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         wr_valid = 1'b0;
  logic [2:0]   wr_addr = 3'd0;
  logic [W-1:0] wr_data = '0;
  logic         commit = 1'b0;
  logic         sample_strobe = 1'b0;
  logic         wr_ready;
  logic [W-1:0] A1, A2, B0, B1, B2;
  logic         filt_rst_n, busy, err;
`ifdef IIR_COEF_READBACK_EN
  logic [2:0]   rd_addr = 3'd0;
  logic [W-1:0] rd_data;
`endif

  int checks = 0;
  int errors = 0;

  iir_coef_ctrl #(.COEF_W(W), .FLUSH_CYCLES(FC)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .wr_valid      (wr_valid),
    .wr_ready      (wr_ready),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .commit        (commit),
    .sample_strobe (sample_strobe),
`ifdef IIR_COEF_READBACK_EN
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
`endif
    .A1            (A1),
    .A2            (A2),
    .B0            (B0),
    .B1            (B1),
    .B2            (B2),
    .filt_rst_n    (filt_rst_n),
    .busy          (busy),
    .err           (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  addr;
    logic [15:0] data;
    logic        exp_err;
    logic [15:0] a1, a2, b0, b1, b2;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_coefs(input string tag, input logic [15:0] e1, input logic [15:0] e2,
                             input logic [15:0] e3, input logic [15:0] e4, input logic [15:0] e5);
    check({tag, ".A1"}, 32'(A1), 32'(e1));
    check({tag, ".A2"}, 32'(A2), 32'(e2));
    check({tag, ".B0"}, 32'(B0), 32'(e3));
    check({tag, ".B1"}, 32'(B1), 32'(e4));
    check({tag, ".B2"}, 32'(B2), 32'(e5));
  endtask

  task automatic do_write(input logic [2:0] a, input logic [15:0] d, input logic with_commit);
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    commit   = with_commit;
    tick();
    wr_valid = 1'b0;
    commit   = 1'b0;
  endtask

  task automatic commit_strobe(input int gap);
    commit = 1'b1;
    tick();
    commit = 1'b0;
    repeat (gap) tick();
    sample_strobe = 1'b1;
    tick();
    sample_strobe = 1'b0;
  endtask

  // Count edges until filt_rst_n rises (bounded), then confirm RUN status
  task automatic measure_flush(input string tag, input int exp_n);
    int n = 0;
    while (filt_rst_n !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
    check({tag, ".flush_len"}, 32'(n), 32'(exp_n));
    check({tag, ".busy_run"}, 32'(busy), 32'd0);
    check({tag, ".ready_run"}, 32'(wr_ready), 32'd1);
  endtask

  // Behavioural reference: phase 0 = flushing, 1 = run, 2 = pending commit
  int          m_phase;
  int          m_left;
  logic [15:0] m_sh  [5];
  logic [15:0] m_act [5];
  logic        m_err;
  logic [15:0] m_rd;

  task automatic model_reset();
    m_phase = 0;
    m_left  = FC;
    m_err   = 1'b0;
    m_rd    = '0;
    for (int i = 0; i < 5; i++) begin
      m_sh[i]  = (i == 2) ? 16'h4000 : 16'h0000;
      m_act[i] = (i == 2) ? 16'h4000 : 16'h0000;
    end
  endtask

  task automatic model_step(input logic [2:0] ra);
    m_rd  = (int'(ra) < 5) ? m_act[int'(ra)] : 16'h0000;
    m_err = (m_phase == 1) && wr_valid && (int'(wr_addr) > 4);
    if (m_phase == 1) begin
      if (wr_valid && int'(wr_addr) < 5) m_sh[int'(wr_addr)] = wr_data;
      if (commit) m_phase = 2;
    end else if (m_phase == 2) begin
      if (sample_strobe) begin
        for (int i = 0; i < 5; i++) m_act[i] = m_sh[i];
        m_phase = 0;
        m_left  = FC;
      end
    end else begin
      m_left--;
      if (m_left == 0) m_phase = 1;
    end
  endtask

  initial begin
    logic [2:0] ra;
    ra = 3'd0;

    vecs[0] = '{3'd1, 16'h2000, 1'b0, 16'h0000, 16'h2000, 16'h4000, 16'h0000, 16'h0000};
    vecs[1] = '{3'd3, 16'hF000, 1'b0, 16'h0000, 16'h2000, 16'h4000, 16'hF000, 16'h0000};
    vecs[2] = '{3'd0, 16'h8001, 1'b0, 16'h8001, 16'h2000, 16'h4000, 16'hF000, 16'h0000};
    vecs[3] = '{3'd7, 16'h5555, 1'b1, 16'h8001, 16'h2000, 16'h4000, 16'hF000, 16'h0000};
    vecs[4] = '{3'd2, 16'h0001, 1'b0, 16'h8001, 16'h2000, 16'h0001, 16'hF000, 16'h0000};
    vecs[5] = '{3'd4, 16'h7FFF, 1'b0, 16'h8001, 16'h2000, 16'h0001, 16'hF000, 16'h7FFF};

    // Reset state
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    check("rst.filt_rst_n", 32'(filt_rst_n), 32'd0);
    check("rst.wr_ready", 32'(wr_ready), 32'd0);
    check("rst.busy", 32'(busy), 32'd1);
    check("rst.err", 32'(err), 32'd0);
    check_coefs("rst", 16'h0000, 16'h0000, 16'h4000, 16'h0000, 16'h0000);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    check("init.busy", 32'(busy), 32'd1);
    measure_flush("init", FC);
    check_coefs("init", 16'h0000, 16'h0000, 16'h4000, 16'h0000, 16'h0000);

    // Writes stay in the shadow bank until the strobe after commit
    do_write(3'd0, 16'hC000, 1'b0);
    do_write(3'd2, 16'h3000, 1'b0);
    check_coefs("shadow_only", 16'h0000, 16'h0000, 16'h4000, 16'h0000, 16'h0000);
    commit = 1'b1;
    tick();
    commit = 1'b0;
    check("pend.busy", 32'(busy), 32'd1);
    check("pend.wr_ready", 32'(wr_ready), 32'd0);
    check("pend.filt_rst_n", 32'(filt_rst_n), 32'd1);
    repeat (5) tick();
    check_coefs("pend_hold", 16'h0000, 16'h0000, 16'h4000, 16'h0000, 16'h0000);
    sample_strobe = 1'b1;
    tick();
    sample_strobe = 1'b0;
    check_coefs("commit1", 16'hC000, 16'h0000, 16'h3000, 16'h0000, 16'h0000);
    check("commit1.filt_fall", 32'(filt_rst_n), 32'd0);
    measure_flush("commit1", FC);

    // Illegal address: handshake completes, err pulses, shadow untouched
    wr_valid = 1'b1;
    wr_addr  = 3'd6;
    wr_data  = 16'h1234;
    check("illegal.ready", 32'(wr_ready), 32'd1);
    tick();
    wr_valid = 1'b0;
    check("illegal.err_hi", 32'(err), 32'd1);
    tick();
    check("illegal.err_lo", 32'(err), 32'd0);
    commit_strobe(0);
    measure_flush("illegal", FC);
    check_coefs("illegal", 16'hC000, 16'h0000, 16'h3000, 16'h0000, 16'h0000);

    // Write and commit in the same cycle
    do_write(3'd4, 16'h0800, 1'b1);
    repeat (2) tick();
    sample_strobe = 1'b1;
    tick();
    sample_strobe = 1'b0;
    measure_flush("samecyc", FC);
    check_coefs("samecyc", 16'hC000, 16'h0000, 16'h3000, 16'h0000, 16'h0800);

    // Commit and write during FLUSH are ignored
    commit_strobe(0);
    wr_valid = 1'b1;
    wr_addr  = 3'd1;
    wr_data  = 16'h1111;
    commit   = 1'b1;
    check("flush.ready", 32'(wr_ready), 32'd0);
    tick();
    wr_valid = 1'b0;
    commit   = 1'b0;
    measure_flush("flush_ign", FC - 1);
    // Strobe in RUN is ignored
    sample_strobe = 1'b1;
    repeat (3) tick();
    sample_strobe = 1'b0;
    check("run_strobe.busy", 32'(busy), 32'd0);
    check("run_strobe.filt", 32'(filt_rst_n), 32'd1);
    // Write in PENDING is refused
    commit = 1'b1;
    tick();
    commit   = 1'b0;
    wr_valid = 1'b1;
    wr_addr  = 3'd1;
    wr_data  = 16'h2222;
    check("pend_wr.ready", 32'(wr_ready), 32'd0);
    tick();
    wr_valid = 1'b0;
    sample_strobe = 1'b1;
    tick();
    sample_strobe = 1'b0;
    measure_flush("pend_wr", FC);
    check_coefs("ignored", 16'hC000, 16'h0000, 16'h3000, 16'h0000, 16'h0800);

    // Asynchronous reset while PENDING
    commit = 1'b1;
    tick();
    commit = 1'b0;
    rst_n = 1'b0;
    #1;
    check_coefs("async_rst", 16'h0000, 16'h0000, 16'h4000, 16'h0000, 16'h0000);
    check("async_rst.filt", 32'(filt_rst_n), 32'd0);
    check("async_rst.busy", 32'(busy), 32'd1);
    #1 rst_n = 1'b1;
    measure_flush("post_rst", FC);
    commit_strobe(0);
    measure_flush("post_rst_commit", FC);
    check_coefs("post_rst_commit", 16'h0000, 16'h0000, 16'h4000, 16'h0000, 16'h0000);

    // Cumulative vector table: one write, then commit, per record
    for (int v = 0; v < 6; v++) begin
      do_write(vecs[v].addr, vecs[v].data, 1'b0);
      check($sformatf("vec%0d.err", v), 32'(err), 32'(vecs[v].exp_err));
      commit_strobe(1);
      measure_flush($sformatf("vec%0d", v), FC);
      check_coefs($sformatf("vec%0d", v), vecs[v].a1, vecs[v].a2, vecs[v].b0, vecs[v].b1, vecs[v].b2);
    end

    // Randomized run against the behavioural model
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    model_reset();
    for (int cyc = 0; cyc < 2000; cyc++) begin
      wr_valid      = 1'($urandom_range(0, 1));
      wr_addr       = 3'($urandom_range(0, 7));
      wr_data       = 16'($urandom);
      commit        = ($urandom_range(0, 7) == 0);
      sample_strobe = ($urandom_range(0, 3) == 0);
      ra            = 3'($urandom_range(0, 7));
`ifdef IIR_COEF_READBACK_EN
      rd_addr = ra;
`endif
      @(posedge clk);
      model_step(ra);
      #1;
      check("rnd.filt_rst_n", 32'(filt_rst_n), 32'(m_phase != 0));
      check("rnd.wr_ready", 32'(wr_ready), 32'(m_phase == 1));
      check("rnd.busy", 32'(busy), 32'(m_phase != 1));
      check("rnd.err", 32'(err), 32'(m_err));
      check_coefs("rnd", m_act[0], m_act[1], m_act[2], m_act[3], m_act[4]);
`ifdef IIR_COEF_READBACK_EN
      check("rnd.rd_data", 32'(rd_data), 32'(m_rd));
`endif
    end
    wr_valid = 1'b0;
    commit = 1'b0;
    sample_strobe = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
